button_event: RTL and testbench

- Downstream consumer of the push-button debouncer's `db` output.
- Converts the debounced, clk-synchronous button level into single-cycle event pulses: press, release, short-click, double-click, long-press and auto-repeat.
- Feeds counter/LED and menu logic on the Spartan-6 board, replacing direct edge-clocking on the debounced signal with a clean clk-domain strobe interface.

---
 rtl/btn_pkg.sv | 16 +
 rtl/edge_detect.sv | 24 ++
 rtl/button_event.sv | 116 +++++++++++
 tb/tb_button_event.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and counter sizing for the button event blocks
package btn_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PRESSED = 3'd1,
      LONG    = 3'd2,
      GAP     = 3'd3,
      SECOND  = 3'd4
   } state_t;
   function automatic int clog2_max(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m) + 1;
   endfunction
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registered copy of a clk-synchronous level with rise/fall strobes
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);
   logic r_q;
   logic r_arm;
   // The first sample after reset only establishes the baseline, so a level that is
   // already high when reset releases is not mistaken for a new edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q   <= 1'b0;
         r_arm <= 1'b0;
      end else begin
         r_q   <= i_d;
         r_arm <= 1'b1;
      end
   end
   assign o_rise = r_arm & i_d & ~r_q;
   assign o_fall = r_arm & ~i_d & r_q;
endmodule

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release/click/long/repeat strobes
module button_event import btn_pkg::*; #(
   parameter int LONG_CYCLES    = 50_000_000,
   parameter int REPEAT_CYCLES  = 10_000_000,
   parameter int DBL_GAP_CYCLES = 12_500_000,
   parameter int DBL_EN         = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic db_in,
   input  logic en,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_pulse,
   output logic double_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);
   localparam int CW = clog2_max(LONG_CYCLES, REPEAT_CYCLES, DBL_GAP_CYCLES);
   localparam logic [CW-1:0] L_END = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] R_END = CW'(REPEAT_CYCLES - 1);
   localparam logic [CW-1:0] G_END = CW'(DBL_GAP_CYCLES - 1);
   state_t r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [5:0] r_stb;
   logic r_held;
   logic w_rise, w_fall;
   logic w_press, w_rel, w_short, w_dbl, w_long, w_rep;
   edge_detect u_edge (
      .clk   (clk),
      .rst   (rst),
      .i_d   (db_in),
      .o_rise(w_rise),
      .o_fall(w_fall)
   );
   // Next state, counter and strobes; a falling or rising edge always outranks a timer
   // expiring in the same cycle, and any state change restarts the counter.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_press     = 1'b0;
      w_rel       = 1'b0;
      w_short     = 1'b0;
      w_dbl       = 1'b0;
      w_long      = 1'b0;
      w_rep       = 1'b0;
      if (!en) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               w_cnt_nxt = '0;
               if (w_rise) begin
                  w_state_nxt = PRESSED;
                  w_press     = 1'b1;
               end
            end
            PRESSED: begin
               if (w_fall) begin
                  w_rel       = 1'b1;
                  w_short     = (DBL_EN == 0);
                  w_state_nxt = (DBL_EN != 0) ? GAP : IDLE;
               end else if (r_cnt == L_END) begin
                  w_long      = 1'b1;
                  w_state_nxt = LONG;
               end
            end
            LONG: begin
               if (w_fall) begin
                  w_rel       = 1'b1;
                  w_state_nxt = IDLE;
               end else if (r_cnt == R_END) begin
                  w_rep     = 1'b1;
                  w_cnt_nxt = '0;
               end
            end
            GAP: begin
               if (w_rise) begin
                  w_press     = 1'b1;
                  w_dbl       = 1'b1;
                  w_state_nxt = SECOND;
               end else if (r_cnt == G_END) begin
                  w_short     = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            SECOND: begin
               w_cnt_nxt = '0;
               if (w_fall) begin
                  w_rel       = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
      if (w_state_nxt != r_state) w_cnt_nxt = '0;
   end
   // State, counter and all outputs are registered so every strobe is glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_stb   <= '0;
         r_held  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_stb   <= {w_press, w_rel, w_short, w_dbl, w_long, w_rep};
         r_held  <= (w_state_nxt == PRESSED) || (w_state_nxt == LONG) || (w_state_nxt == SECOND);
      end
   end
   assign {press_pulse, release_pulse, short_pulse, double_pulse, long_pulse, repeat_pulse} = r_stb;
   assign held = r_held;
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: table, directed and random checks of button_event against a timestamp model
module tb_button_event;
   localparam int L = 8;
   localparam int R = 4;
   localparam int G = 6;
   localparam int B_PR = 6, B_RL = 5, B_SH = 4, B_DB = 3, B_LG = 2, B_RP = 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic db_in = 1'b0;
   logic en = 1'b1;
   wire [6:0] o1;
   wire [6:0] o0;
   always #5 clk = ~clk;
   button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .DBL_GAP_CYCLES(G), .DBL_EN(1)) u_dut1 (
      .clk(clk), .rst(rst), .db_in(db_in), .en(en),
      .press_pulse(o1[6]), .release_pulse(o1[5]), .short_pulse(o1[4]), .double_pulse(o1[3]),
      .long_pulse(o1[2]), .repeat_pulse(o1[1]), .held(o1[0])
   );
   button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .DBL_GAP_CYCLES(G), .DBL_EN(0)) u_dut0 (
      .clk(clk), .rst(rst), .db_in(db_in), .en(en),
      .press_pulse(o0[6]), .release_pulse(o0[5]), .short_pulse(o0[4]), .double_pulse(o0[3]),
      .long_pulse(o0[2]), .repeat_pulse(o0[1]), .held(o0[0])
   );
   typedef struct {
      logic       db;
      logic       en;
      logic [6:0] e1;
      logic [6:0] e0;
   } vec_t;
   vec_t tbl[13];
   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int pc[2][7];
   int lc[2][7];
   // model state: timestamps of the current press, long threshold and pending release
   bit m_p, m_have;
   bit m_pr[2], m_sec[2];
   int m_pat[2], m_lat[2], m_gap[2];
   logic [6:0] exp_v[2];
   task automatic chkv(input string nm, input logic [6:0] got, input logic [6:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b expected %b (press,rel,short,dbl,long,rep,held)", nm, cyc, got, exp);
      end
   endtask
   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
      end
   endtask
   task automatic model_edge();
      bit rise, fall, pr, rl, sh, dd, lg, rp;
      cyc++;
      if (rst) begin
         m_have = 1'b0;
         m_p = 1'b0;
         for (int v = 0; v < 2; v++) begin
            m_pr[v] = 1'b0;
            m_gap[v] = -1;
            exp_v[v] = '0;
         end
         return;
      end
      rise = m_have && db_in && !m_p;
      fall = m_have && !db_in && m_p;
      m_p = db_in;
      m_have = 1'b1;
      for (int v = 0; v < 2; v++) begin
         pr = 0; rl = 0; sh = 0; dd = 0; lg = 0; rp = 0;
         if (!en) begin
            m_pr[v] = 1'b0;
            m_gap[v] = -1;
         end else if (m_pr[v]) begin
            if (fall) begin
               rl = 1;
               m_pr[v] = 1'b0;
               if (!m_sec[v] && m_lat[v] < 0) begin
                  if (v == 1) m_gap[v] = cyc;
                  else sh = 1;
               end
            end else if (!m_sec[v]) begin
               if (m_lat[v] < 0) begin
                  if (cyc - m_pat[v] == L) begin
                     lg = 1;
                     m_lat[v] = cyc;
                  end
               end else if ((cyc - m_lat[v]) % R == 0) rp = 1;
            end
         end else if (m_gap[v] >= 0) begin
            if (rise) begin
               pr = 1; dd = 1;
               m_pr[v] = 1'b1; m_sec[v] = 1'b1; m_pat[v] = cyc; m_lat[v] = -1; m_gap[v] = -1;
            end else if (cyc - m_gap[v] == G) begin
               sh = 1;
               m_gap[v] = -1;
            end
         end else if (rise) begin
            pr = 1;
            m_pr[v] = 1'b1; m_sec[v] = 1'b0; m_pat[v] = cyc; m_lat[v] = -1;
         end
         exp_v[v] = {pr, rl, sh, dd, lg, rp, m_pr[v]};
      end
   endtask
   task automatic step(input logic d, input logic e);
      logic [6:0] ov;
      db_in = d;
      en = e;
      @(posedge clk);
      model_edge();
      #1;
      chkv("dbl_en1 vs model", o1, exp_v[1]);
      chkv("dbl_en0 vs model", o0, exp_v[0]);
      for (int v = 0; v < 2; v++) begin
         ov = (v == 1) ? o1 : o0;
         for (int b = 1; b < 7; b++) if (ov[b]) begin
            pc[v][b]++;
            lc[v][b] = cyc;
         end
      end
   endtask
   task automatic run(input logic d, input logic e, input int k);
      repeat (k) step(d, e);
   endtask
   task automatic clr();
      for (int v = 0; v < 2; v++) for (int b = 0; b < 7; b++) begin
         pc[v][b] = 0;
         lc[v][b] = 0;
      end
   endtask
   initial begin
      int len;
      logic d, e;
      tbl = '{
         '{1'b0, 1'b1, 7'b0000000, 7'b0000000},
         '{1'b0, 1'b1, 7'b0000000, 7'b0000000},
         '{1'b1, 1'b1, 7'b1000001, 7'b1000001},
         '{1'b1, 1'b1, 7'b0000001, 7'b0000001},
         '{1'b1, 1'b1, 7'b0000001, 7'b0000001},
         '{1'b0, 1'b1, 7'b0100000, 7'b0110000},
         '{1'b0, 1'b1, 7'b0000000, 7'b0000000},
         '{1'b0, 1'b1, 7'b0000000, 7'b0000000},
         '{1'b0, 1'b1, 7'b0000000, 7'b0000000},
         '{1'b0, 1'b1, 7'b0000000, 7'b0000000},
         '{1'b0, 1'b1, 7'b0000000, 7'b0000000},
         '{1'b0, 1'b1, 7'b0010000, 7'b0000000},
         '{1'b0, 1'b1, 7'b0000000, 7'b0000000}
      };
      clr();
      #1;
      chkv("reset dbl_en1", o1, 7'b0);
      chkv("reset dbl_en0", o0, 7'b0);
      run(1'b0, 1'b1, 2);
      rst = 1'b0;
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].db, tbl[i].en);
         chkv("table dbl_en1", o1, tbl[i].e1);
         chkv("table dbl_en0", o0, tbl[i].e0);
      end
      clr();
      run(1'b1, 1'b1, 21);
      run(1'b0, 1'b1, 10);
      chk("long count", pc[1][B_LG], 1);
      chk("long after press", lc[1][B_LG] - lc[1][B_PR], 8);
      chk("repeat count", pc[1][B_RP], 3);
      chk("last repeat after long", lc[1][B_RP] - lc[1][B_LG], 12);
      chk("long hold releases", pc[1][B_RL], 1);
      chk("long hold shorts", pc[1][B_SH] + pc[0][B_SH], 0);
      clr();
      run(1'b1, 1'b1, 2);
      run(1'b0, 1'b1, 2);
      run(1'b1, 1'b1, 2);
      run(1'b0, 1'b1, 10);
      chk("double count", pc[1][B_DB], 1);
      chk("double with press", lc[1][B_DB], lc[1][B_PR]);
      chk("double releases", pc[1][B_RL], 2);
      chk("double shorts", pc[1][B_SH], 0);
      chk("dbl_en0 no double", pc[0][B_DB], 0);
      chk("dbl_en0 two shorts", pc[0][B_SH], 2);
      clr();
      run(1'b1, 1'b1, 8);
      run(1'b0, 1'b1, 10);
      chk("fall at long edge no long", pc[1][B_LG], 0);
      chk("fall at long edge short", pc[1][B_SH], 1);
      chk("short after release", lc[1][B_SH] - lc[1][B_RL], 6);
      clr();
      run(1'b1, 1'b1, 2);
      run(1'b0, 1'b1, 6);
      run(1'b1, 1'b1, 2);
      run(1'b0, 1'b1, 10);
      chk("rise at gap end double", pc[1][B_DB], 1);
      chk("rise at gap end no short", pc[1][B_SH], 0);
      clr();
      run(1'b1, 1'b1, 2);
      run(1'b0, 1'b1, 7);
      run(1'b1, 1'b1, 2);
      run(1'b0, 1'b1, 10);
      chk("rise after gap no double", pc[1][B_DB], 0);
      chk("rise after gap shorts", pc[1][B_SH], 2);
      run(1'b1, 1'b1, 12);
      chk("held in long", o1[0], 1);
      #2;
      rst = 1'b1;
      #1;
      chkv("async reset dbl_en1", o1, 7'b0);
      chkv("async reset dbl_en0", o0, 7'b0);
      run(1'b1, 1'b1, 2);
      rst = 1'b0;
      clr();
      run(1'b1, 1'b1, 10);
      chk("no press after reset", pc[1][B_PR] + pc[0][B_PR], 0);
      run(1'b0, 1'b1, 10);
      clr();
      run(1'b1, 1'b1, 2);
      chk("press before disable", pc[1][B_PR], 1);
      clr();
      run(1'b1, 1'b0, 3);
      run(1'b1, 1'b1, 4);
      chk("no press on enable while held", pc[1][B_PR] + pc[0][B_PR], 0);
      clr();
      run(1'b0, 1'b1, 2);
      run(1'b1, 1'b1, 2);
      chk("press after re-press", pc[1][B_PR], 1);
      run(1'b0, 1'b1, 10);
      for (int i = 0; i < 300; i++) begin
         len = $urandom_range(1, 25);
         d = 1'($urandom_range(0, 1));
         e = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            step(d, e);
            rst = 1'b0;
         end
         run(d, e, len);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end
endmodule
